// File: rtl/overlay_pkg.sv
// Shared types for the debug overlay compositor.
// Holds the layer mode encodings, the per-layer config struct and the
// power-on default (white, solid) used to reproduce the old single-colour
// renderer without any configuration.
package overlay_pkg;

    // Widest colour the config struct can hold (3 channels x 8 bits).
    localparam int RGB_MAX_W = 24;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [RGB_MAX_W-1:0] rgb;
        mode_e                mode;
    } layer_cfg_t;

    localparam logic [RGB_MAX_W-1:0] WHITE_RGB = '1;

    // White limited to the bits a COLOR_W-per-channel pixel actually uses,
    // so the unused upper bits stay zero.
    function automatic layer_cfg_t default_layer_cfg(input int color_w);
        layer_cfg_t cfg;
        cfg.rgb = '0;
        for (int k = 0; k < RGB_MAX_W; k++) begin
            if (k < 3 * color_w) begin
                cfg.rgb[k] = WHITE_RGB[k];
            end
        end
        cfg.mode = MODE_SOLID;
        return cfg;
    endfunction

endpackage

// File: rtl/overlay_priority_enc.sv
// First-one priority encoder: returns the lowest set index of req.
// Ports:
//   req   - request vector, bit 0 has highest priority
//   idx   - index of the lowest set bit (0 when none set)
//   valid - high when any bit of req is set
module overlay_priority_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_overlay_compositor.sv
// Debug overlay compositor.
// Merges per-layer hit flags into one RGB pixel stream through a 2-stage
// pipeline, applying per-layer colour, priority and blink mode, and
// snapshots the debug data bus once per frame for tear-free rendering.
// Ports:
//   clk, rst         - pixel clock, synchronous active-high reset
//   x, y             - current pixel coordinate
//   hit              - per-layer hit flags for (x, y), same cycle
//   data_in          - live debug data
//   data_snap        - copy of data_in taken at the frame point
//   cfg_we/cfg_layer/cfg_rgb/cfg_mode - shadow config write port
//   frame_tick       - one-cycle pulse the cycle after the frame point
//   r, g, b          - registered pixel colour, 2 cycles after x/y/hit
module debug_overlay_compositor
    import overlay_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int COORD_W      = 11,
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_W      = 3,
    parameter int DATA_W       = 176,
    parameter int BLINK_FRAMES = 30,
    parameter logic [3*COLOR_W-1:0] BG_RGB = '0,
    parameter int LAYER_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COORD_W-1:0]     x,
    input  logic [COORD_W-1:0]     y,
    input  logic [NUM_LAYERS-1:0]  hit,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_snap,
    input  logic                   cfg_we,
    input  logic [LAYER_W-1:0]     cfg_layer,
    input  logic [3*COLOR_W-1:0]   cfg_rgb,
    input  logic [1:0]             cfg_mode,
    output logic                   frame_tick,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b
);

    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam layer_cfg_t DEFAULT_CFG = default_layer_cfg(COLOR_W);

    layer_cfg_t shadow_cfg [NUM_LAYERS];
    layer_cfg_t shadow_next[NUM_LAYERS];
    layer_cfg_t active_cfg [NUM_LAYERS];

    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blink_phase;
    logic                  frame_pt;
    logic [NUM_LAYERS-1:0] eff_hit;
    logic [LAYER_W-1:0]    win_idx;
    logic                  win_valid;
    logic                  s1_active;
    logic [LAYER_W-1:0]    s1_idx;
    logic                  s1_valid;
    logic [3*COLOR_W-1:0]  pix_rgb;
    logic                  unused_rgb_bits;

    assign frame_pt = (x == '0) && (y == COORD_W'(V_ACTIVE));

    // Shadow config with this cycle's write applied, so a write landing on
    // the frame point is part of that commit.
    always_comb begin
        shadow_next = shadow_cfg;
        if (cfg_we && (32'(cfg_layer) < NUM_LAYERS)) begin
            shadow_next[cfg_layer].rgb  = RGB_MAX_W'(cfg_rgb);
            shadow_next[cfg_layer].mode = mode_e'(cfg_mode);
        end
    end

    // Blink-mode layers drop out during phase 1; off and reserved never hit.
    always_comb begin
        eff_hit = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eff_hit[i] = hit[i] &&
                         ((active_cfg[i].mode == MODE_SOLID) ||
                          ((active_cfg[i].mode == MODE_BLINK) && !blink_phase));
        end
    end

    overlay_priority_enc #(
        .N     (NUM_LAYERS),
        .IDX_W (LAYER_W)
    ) u_prio (
        .req   (eff_hit),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_comb begin
        pix_rgb = '0;
        if (s1_active) begin
            pix_rgb = s1_valid ? active_cfg[s1_idx].rgb[3*COLOR_W-1:0] : BG_RGB;
        end
    end

    // Upper struct bits above 3*COLOR_W are always zero and never displayed.
    always_comb begin
        unused_rgb_bits = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            unused_rgb_bits = unused_rgb_bits ^ (^active_cfg[i].rgb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_snap   <= '0;
            frame_tick  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            s1_active   <= 1'b0;
            s1_idx      <= '0;
            s1_valid    <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow_cfg[i] <= DEFAULT_CFG;
                active_cfg[i] <= DEFAULT_CFG;
            end
        end else begin
            frame_tick <= frame_pt;
            shadow_cfg <= shadow_next;
            if (frame_pt) begin
                data_snap  <= data_in;
                active_cfg <= shadow_next;
                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            s1_active <= (x < COORD_W'(H_ACTIVE)) && (y < COORD_W'(V_ACTIVE));
            s1_idx    <= win_idx;
            s1_valid  <= win_valid;
            {r, g, b} <= pix_rgb;
        end
    end

endmodule

// File: tb/tb_debug_overlay_compositor.sv
// Directed testbench for debug_overlay_compositor (BLINK_FRAMES=2).
module tb_debug_overlay_compositor;

    logic         clk;
    logic         rst;
    logic [10:0]  x;
    logic [10:0]  y;
    logic [3:0]   hit;
    logic [175:0] data_in;
    logic [175:0] data_snap;
    logic         cfg_we;
    logic [1:0]   cfg_layer;
    logic [8:0]   cfg_rgb;
    logic [1:0]   cfg_mode;
    logic         frame_tick;
    logic [2:0]   r;
    logic [2:0]   g;
    logic [2:0]   b;

    int           checks;
    int           passes;
    int           fp_count;
    logic [175:0] exp_snap;

    debug_overlay_compositor #(
        .H_ACTIVE     (640),
        .V_ACTIVE     (480),
        .COORD_W      (11),
        .NUM_LAYERS   (4),
        .COLOR_W      (3),
        .DATA_W       (176),
        .BLINK_FRAMES (2),
        .BG_RGB       (9'h000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .hit        (hit),
        .data_in    (data_in),
        .data_snap  (data_snap),
        .cfg_we     (cfg_we),
        .cfg_layer  (cfg_layer),
        .cfg_rgb    (cfg_rgb),
        .cfg_mode   (cfg_mode),
        .frame_tick (frame_tick),
        .r          (r),
        .g          (g),
        .b          (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [175:0] rand_data();
        logic [191:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return v[175:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int xx, input int yy, input logic [3:0] h);
        x   = 11'(xx);
        y   = 11'(yy);
        hit = h;
    endtask

    // Presents one pixel and returns its colour two clocks later.
    task automatic pixel_rgb(input int xx, input int yy, input logic [3:0] h,
                             output logic [8:0] rgb);
        drive(xx, yy, h);
        step();
        drive(xx + 1, yy, 4'b0000);
        step();
        rgb = {r, g, b};
    endtask

    task automatic write_cfg(input logic [1:0] layer, input logic [8:0] rgb,
                             input logic [1:0] mode);
        cfg_we    = 1'b1;
        cfg_layer = layer;
        cfg_rgb   = rgb;
        cfg_mode  = mode;
        drive(50, 100, 4'b0000);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic frame_point();
        drive(0, 480, 4'b0000);
        exp_snap = data_in;
        step();
        fp_count++;
        drive(1, 480, 4'b0000);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        cfg_we  = 1'b0;
        data_in = '0;
        drive(0, 0, 4'b0000);
        step();
        step();
        step();
        rst      = 1'b0;
        fp_count = 0;
        exp_snap = '0;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        rst     = 1'b1;
        cfg_we  = 1'b0;
        data_in = rand_data();
        drive(10, 10, 4'b1111);
        step();
        step();
        checks++;
        if ({r, g, b} !== 9'h000) $display("[TB] FAIL reset_rgb: got %h expected 000", {r, g, b});
        else passes++;
        checks++;
        if (data_snap !== 176'h0) $display("[TB] FAIL reset_snap: got %h expected 0", data_snap);
        else passes++;
        checks++;
        if (frame_tick !== 1'b0) $display("[TB] FAIL reset_tick: got %b expected 0", frame_tick);
        else passes++;
        do_reset();
        pixel_rgb(10, 10, 4'b0100, got);
        checks++;
        if (got !== 9'h1FF) $display("[TB] FAIL default_white: got %h expected 1ff", got);
        else passes++;
        pixel_rgb(10, 10, 4'b0000, got);
        checks++;
        if (got !== 9'h000) $display("[TB] FAIL default_bg: got %h expected 000", got);
        else passes++;
    endtask

    task automatic test_priority();
        logic [8:0] got;
        write_cfg(2'd1, 9'h1C0, 2'd1);
        write_cfg(2'd2, 9'h007, 2'd1);
        pixel_rgb(20, 30, 4'b0110, got);
        checks++;
        if (got !== 9'h1FF) $display("[TB] FAIL midframe_no_commit: got %h expected 1ff", got);
        else passes++;
        frame_point();
        pixel_rgb(20, 30, 4'b0110, got);
        checks++;
        if (got !== 9'h1C0) $display("[TB] FAIL prio_layer1: got %h expected 1c0", got);
        else passes++;
        pixel_rgb(20, 30, 4'b0100, got);
        checks++;
        if (got !== 9'h007) $display("[TB] FAIL layer2_only: got %h expected 007", got);
        else passes++;
        write_cfg(2'd1, 9'h1C0, 2'd0);
        pixel_rgb(20, 30, 4'b0110, got);
        checks++;
        if (got !== 9'h1C0) $display("[TB] FAIL off_before_commit: got %h expected 1c0", got);
        else passes++;
        frame_point();
        pixel_rgb(20, 30, 4'b0110, got);
        checks++;
        if (got !== 9'h007) $display("[TB] FAIL layer1_off: got %h expected 007", got);
        else passes++;
        write_cfg(2'd2, 9'h007, 2'd3);
        frame_point();
        pixel_rgb(20, 30, 4'b0110, got);
        checks++;
        if (got !== 9'h000) $display("[TB] FAIL reserved_mode: got %h expected 000", got);
        else passes++;
    endtask

    task automatic test_commit_on_fp();
        logic [8:0] got;
        pixel_rgb(30, 40, 4'b1000, got);
        checks++;
        if (got !== 9'h1FF) $display("[TB] FAIL layer3_default: got %h expected 1ff", got);
        else passes++;
        cfg_we    = 1'b1;
        cfg_layer = 2'd3;
        cfg_rgb   = 9'h038;
        cfg_mode  = 2'd1;
        frame_point();
        cfg_we = 1'b0;
        pixel_rgb(30, 40, 4'b1000, got);
        checks++;
        if (got !== 9'h038) $display("[TB] FAIL write_through: got %h expected 038", got);
        else passes++;
    endtask

    task automatic test_blink();
        logic [8:0] got;
        logic [8:0] expv [5];
        expv[0] = 9'h1FF;
        expv[1] = 9'h1C0;
        expv[2] = 9'h038;
        expv[3] = 9'h038;
        expv[4] = 9'h1C0;
        do_reset();
        write_cfg(2'd0, 9'h1C0, 2'd2);
        write_cfg(2'd1, 9'h038, 2'd1);
        for (int f = 0; f < 5; f++) begin
            if (f > 0) frame_point();
            pixel_rgb(100, 200, 4'b0011, got);
            checks++;
            if (got !== expv[f]) $display("[TB] FAIL blink_frame%0d: got %h expected %h", f, got, expv[f]);
            else passes++;
        end
    endtask

    task automatic test_snapshot();
        logic [175:0] v;
        int ticks;
        for (int i = 0; i < 16; i++) begin
            data_in = rand_data();
            drive(i, 50, 4'b0000);
            step();
            checks++;
            if (data_snap !== exp_snap || frame_tick !== 1'b0)
                $display("[TB] FAIL snap_hold%0d: got %h/%b expected %h/0", i, data_snap, frame_tick, exp_snap);
            else passes++;
        end
        v       = rand_data();
        data_in = v;
        drive(0, 480, 4'b0000);
        step();
        fp_count++;
        checks++;
        if (data_snap !== v) $display("[TB] FAIL snap_capture: got %h expected %h", data_snap, v);
        else passes++;
        checks++;
        if (frame_tick !== 1'b1) $display("[TB] FAIL tick_pulse: got %b expected 1", frame_tick);
        else passes++;
        data_in = rand_data();
        drive(1, 480, 4'b0000);
        step();
        checks++;
        if (data_snap !== v || frame_tick !== 1'b0)
            $display("[TB] FAIL snap_after: got %h/%b expected %h/0", data_snap, frame_tick, v);
        else passes++;
        exp_snap = v;
        ticks = 0;
        for (int c = 0; c < 40; c++) begin
            data_in = rand_data();
            if (c == 20) begin
                frame_point();
            end else begin
                drive(c + 100, (c < 20) ? 470 : 481, 4'b0000);
                step();
            end
            if (frame_tick === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 1) $display("[TB] FAIL tick_count: got %0d expected 1", ticks);
        else passes++;
    endtask

    task automatic test_blanking_and_reset();
        logic [8:0] got;
        pixel_rgb(700, 10, 4'b1111, got);
        checks++;
        if (got !== 9'h000) $display("[TB] FAIL hblank: got %h expected 000", got);
        else passes++;
        pixel_rgb(10, 500, 4'b1111, got);
        checks++;
        if (got !== 9'h000) $display("[TB] FAIL vblank: got %h expected 000", got);
        else passes++;
        // Leave the blink counter mid-cycle so a missed restart is visible.
        while ((fp_count % 4) == 0 || (fp_count % 4) == 3) frame_point();
        drive(10, 10, 4'b0001);
        step();
        rst = 1'b1;
        drive(11, 10, 4'b0001);
        step();
        checks++;
        if ({r, g, b} !== 9'h000) $display("[TB] FAIL midline_reset: got %h expected 000", {r, g, b});
        else passes++;
        rst      = 1'b0;
        fp_count = 0;
        exp_snap = '0;
        drive(12, 10, 4'b0001);
        step();
        checks++;
        if ({r, g, b} !== 9'h000) $display("[TB] FAIL pipe_flush: got %h expected 000", {r, g, b});
        else passes++;
        drive(13, 10, 4'b0000);
        step();
        checks++;
        if ({r, g, b} !== 9'h1FF) $display("[TB] FAIL first_after_reset: got %h expected 1ff", {r, g, b});
        else passes++;
        write_cfg(2'd0, 9'h1C0, 2'd2);
        write_cfg(2'd1, 9'h038, 2'd1);
        frame_point();
        pixel_rgb(10, 10, 4'b0011, got);
        checks++;
        if (got !== 9'h1C0) $display("[TB] FAIL blink_restart1: got %h expected 1c0", got);
        else passes++;
        frame_point();
        pixel_rgb(10, 10, 4'b0011, got);
        checks++;
        if (got !== 9'h038) $display("[TB] FAIL blink_restart2: got %h expected 038", got);
        else passes++;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        fp_count  = 0;
        exp_snap  = '0;
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_layer = '0;
        cfg_rgb   = '0;
        cfg_mode  = '0;
        data_in   = '0;
        x         = '0;
        y         = '0;
        hit       = '0;
        test_reset();
        test_priority();
        test_commit_on_fp();
        test_blink();
        test_snapshot();
        test_blanking_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
